// File: rtl/input_mapper.sv
// Player-input front end: merges PS/2 key events (via a runtime key map) and HPS joysticks,
// stretches coin pulses, and optionally applies autofire when AUTOFIRE_EN is defined.
module input_mapper #(
  parameter int PLAYERS         = 2,
  parameter int BUTTONS         = 3,
  parameter int MAP_DEPTH       = 32,
  parameter int COIN_CYCLES     = 16,
  parameter int AUTOFIRE_PERIOD = 4096,
  localparam int JOY_W          = BUTTONS + 7,
  localparam int AW             = $clog2(MAP_DEPTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [10:0]                ps2_key,
  input  logic [PLAYERS*JOY_W-1:0]   joystick_in,
  input  logic                       map_wr,
  input  logic [AW-1:0]              map_addr,
  input  logic [15:0]                map_data,
  input  logic [PLAYERS*BUTTONS-1:0] autofire_mask,
  output logic [PLAYERS*JOY_W-1:0]   joystick_out,
  output logic                       key_event
);

  localparam int CW = $clog2(COIN_CYCLES + 1);
  localparam int COIN_BIT = BUTTONS + 5;

  logic                     r_prev_toggle;
  logic [15:0]              r_map [MAP_DEPTH];
  logic [MAP_DEPTH-1:0]     r_key_down;
  logic                     r_hit;
  logic                     r_key_event;
  logic [PLAYERS*JOY_W-1:0] r_joy_out;
  logic [CW-1:0]            r_coin_cnt [PLAYERS];
  logic [PLAYERS-1:0]       r_coin_prev;

  logic                     w_event;
  logic                     w_hit;
  logic [MAP_DEPTH-1:0]     w_match;
  logic [PLAYERS*JOY_W-1:0] w_raw;
  logic [PLAYERS*JOY_W-1:0] w_next;

  assign w_event = ps2_key[10] ^ r_prev_toggle;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < MAP_DEPTH; i++)
      w_match[i] = w_event & r_map[i][15] & (r_map[i][8:0] == ps2_key[8:0]);
  end

  assign w_hit = |w_match;

  // Entries bound to a player or bit outside the vector never match any (p,b) here.
  always_comb begin
    w_raw = joystick_in;
    for (int p = 0; p < PLAYERS; p++)
      for (int b = 0; b < JOY_W; b++)
        for (int i = 0; i < MAP_DEPTH; i++)
          if (r_map[i][15] && (r_map[i][14:13] == 2'(p)) && (r_map[i][12:9] == 4'(b)))
            w_raw[p*JOY_W+b] = w_raw[p*JOY_W+b] | r_key_down[i];
  end

`ifdef AUTOFIRE_EN
  localparam int AFW = $clog2(AUTOFIRE_PERIOD);

  logic [AFW-1:0] r_af_cnt;
  logic           r_af_phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b1;
    end else if (r_af_cnt == AFW'(AUTOFIRE_PERIOD - 1)) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt <= r_af_cnt + 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = (^autofire_mask) ^ (AUTOFIRE_PERIOD > 1);
`endif

  always_comb begin
    w_next = w_raw;
    for (int p = 0; p < PLAYERS; p++)
      w_next[p*JOY_W+COIN_BIT] = w_raw[p*JOY_W+COIN_BIT] | (r_coin_cnt[p] != '0);
`ifdef AUTOFIRE_EN
    for (int p = 0; p < PLAYERS; p++)
      for (int k = 0; k < BUTTONS; k++)
        if (autofire_mask[p*BUTTONS+k])
          w_next[p*JOY_W+4+k] = w_raw[p*JOY_W+4+k] & r_af_phase;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_toggle <= ps2_key[10];
      for (int i = 0; i < MAP_DEPTH; i++) r_map[i] <= '0;
      r_key_down  <= '0;
      r_hit       <= 1'b0;
      r_key_event <= 1'b0;
      r_joy_out   <= '0;
      r_coin_prev <= '0;
      for (int p = 0; p < PLAYERS; p++) r_coin_cnt[p] <= '0;
    end else begin
      r_prev_toggle <= ps2_key[10];
      r_hit         <= w_hit;
      r_key_event   <= r_hit;
      r_joy_out     <= w_next;
      // A map write clears its entry's key state even if an event hits it the same cycle.
      for (int i = 0; i < MAP_DEPTH; i++) begin
        if (map_wr && (map_addr == AW'(i))) begin
          r_map[i]      <= map_data;
          r_key_down[i] <= 1'b0;
        end else if (w_match[i]) begin
          r_key_down[i] <= ps2_key[9];
        end
      end
      for (int p = 0; p < PLAYERS; p++) begin
        r_coin_prev[p] <= w_raw[p*JOY_W+COIN_BIT];
        if (w_raw[p*JOY_W+COIN_BIT] && !r_coin_prev[p])
          r_coin_cnt[p] <= CW'(COIN_CYCLES - 1);
        else if (r_coin_cnt[p] != '0)
          r_coin_cnt[p] <= r_coin_cnt[p] - 1'b1;
      end
    end
  end

  assign joystick_out = r_joy_out;
  assign key_event    = r_key_event;

endmodule
